// File: rtl/gate_pkg.sv
// Shared operation codes and gate evaluation for the gate sequencer.
package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_NOT  = 3'd5
    } op_e;

    localparam int unsigned OP_COUNT = 6;

    // Codes 6-7 are unreachable; they evaluate to 0 so a corrupted register stays dark.
    function automatic logic gate_eval(input logic [2:0] op, input logic a, input logic b);
        logic res;
        case (op)
            OP_AND:  res = a & b;
            OP_NAND: res = ~(a & b);
            OP_OR:   res = a | b;
            OP_NOR:  res = ~(a | b);
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [2:0] next_op(input logic [2:0] op);
        return (op >= 3'(OP_COUNT - 1)) ? 3'(OP_AND) : op + 3'd1;
    endfunction

endpackage

// File: rtl/gate_debounce.sv
// Step-button conditioning: 2-flop synchroniser, debounce counter and a one-cycle
// pulse on each accepted rising edge.
module gate_debounce
    import gate_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_step
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync0_q, sync1_q;
    logic [1:0]      fill_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            armed_q, armed_d;
    logic            step_q, step_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        step_d  = 1'b0;
        // Only arm once a genuinely released button has been seen after reset, so a
        // button held through reset release never produces a step.
        armed_d = armed_q | (fill_q[1] & ~sync1_q);
        if (sync1_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync1_q;
                step_d  = sync1_q & armed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            fill_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            sync0_q <= i_btn;
            sync1_q <= sync0_q;
            fill_q  <= {fill_q[0], 1'b1};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            step_q  <= step_d;
        end
    end

    assign o_step = step_q;

endmodule

// File: rtl/gate_sequencer.sv
// Gate sequencer top: steps through six gate operations on debounced button presses.
// Optional auto-scan timer enabled by defining GATE_SEQ_AUTOSCAN_EN.
module gate_sequencer
    import gate_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SCAN_CYCLES     = 100_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_switch_0,
    input  logic       i_switch_1,
    input  logic       i_btn_step,
    input  logic       i_auto,
    output logic [2:0] o_op_sel,
    output logic [5:0] o_op_onehot,
    output logic       o_result
);

    logic       a_s0_q, a_s1_q, b_s0_q, b_s1_q;
    logic       btn_step;
    logic       advance;
    logic [2:0] op_q, op_d;
    logic [5:0] onehot_q, onehot_d;
    logic       result_q, result_d;

    gate_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_btn  (i_btn_step),
        .o_step (btn_step)
    );

`ifdef GATE_SEQ_AUTOSCAN_EN
    localparam int unsigned ScanW = $clog2(SCAN_CYCLES);
    localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_CYCLES - 1);

    logic             auto_s0_q, auto_s1_q;
    logic [ScanW-1:0] scan_q, scan_d;
    logic             scan_tick;

    // A button step restarts the period so scan ticks stay evenly spaced after a press.
    always_comb begin
        scan_tick = auto_s1_q && (scan_q == ScanMax);
        if (!auto_s1_q || btn_step || scan_tick) begin
            scan_d = '0;
        end else begin
            scan_d = scan_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            auto_s0_q <= 1'b0;
            auto_s1_q <= 1'b0;
            scan_q    <= '0;
        end else begin
            auto_s0_q <= i_auto;
            auto_s1_q <= auto_s0_q;
            scan_q    <= scan_d;
        end
    end

    assign advance = btn_step | scan_tick;
`else
    logic unused_auto;
    assign unused_auto = i_auto ^ SCAN_CYCLES[0];
    assign advance     = btn_step;
`endif

    // Outputs decode the next-state op so LEDs and op_sel change on the same edge.
    always_comb begin
        op_d     = advance ? next_op(op_q) : op_q;
        onehot_d = 6'b000001 << op_d;
        result_d = gate_eval(op_d, a_s1_q, b_s1_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_s0_q   <= 1'b0;
            a_s1_q   <= 1'b0;
            b_s0_q   <= 1'b0;
            b_s1_q   <= 1'b0;
            op_q     <= 3'(OP_AND);
            onehot_q <= 6'b000001;
            result_q <= 1'b0;
        end else begin
            a_s0_q   <= i_switch_0;
            a_s1_q   <= a_s0_q;
            b_s0_q   <= i_switch_1;
            b_s1_q   <= b_s0_q;
            op_q     <= op_d;
            onehot_q <= onehot_d;
            result_q <= result_d;
        end
    end

    assign o_op_sel    = op_q;
    assign o_op_onehot = onehot_q;
    assign o_result    = result_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Scoreboard bench for gate_sequencer: stimulus queues expected snapshots and steps,
// a negedge monitor checks them against the outputs.
module tb_gate_sequencer;

    localparam int unsigned DebCycles  = 4;
    localparam int unsigned ScanCycles = 8;
    // Result per op code with A=1, B=0: AND 0, NAND 1, OR 1, NOR 0, XOR 1, NOT 0.
    localparam logic [5:0] ResA1B0 = 6'b010110;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       sw0     = 1'b0;
    logic       sw1     = 1'b0;
    logic       btn     = 1'b0;
    logic       auto_en = 1'b0;
    logic [2:0] op_sel;
    logic [5:0] op_onehot;
    logic       result;

    typedef struct {
        int unsigned at;
        logic [2:0]  op;
        logic        res;
        string       name;
    } exp_t;

    exp_t        snap_q[$];
    exp_t        step_q[$];
    exp_t        cur;
    int unsigned cyc      = 0;
    int          checks   = 0;
    int          failures = 0;
    logic [2:0]  exp_op   = 3'd0;
    logic [2:0]  prev_op  = 3'd0;

    gate_sequencer #(
        .DEBOUNCE_CYCLES(DebCycles),
        .SCAN_CYCLES    (ScanCycles)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_switch_0 (sw0),
        .i_switch_1 (sw1),
        .i_btn_step (btn),
        .i_auto     (auto_en),
        .o_op_sel   (op_sel),
        .o_op_onehot(op_onehot),
        .o_result   (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_snap(input string name, input int unsigned at, input logic [2:0] op,
                             input logic res);
        exp_t e;
        e.at   = at;
        e.op   = op;
        e.res  = res;
        e.name = name;
        snap_q.push_back(e);
    endtask

    task automatic push_step(input int unsigned at);
        exp_t e;
        exp_op = (exp_op == 3'd5) ? 3'd0 : exp_op + 3'd1;
        e.at   = at;
        e.op   = exp_op;
        e.res  = ResA1B0[exp_op];
        e.name = "step";
        step_q.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = snap_q.size() - 1; i >= 0; i--) begin
            if (snap_q[i].at == cyc) begin
                check({snap_q[i].name, "_op"}, 32'(op_sel), 32'(snap_q[i].op));
                check({snap_q[i].name, "_onehot"}, 32'(op_onehot),
                      32'(6'b000001 << snap_q[i].op));
                check({snap_q[i].name, "_result"}, 32'(result), 32'(snap_q[i].res));
                snap_q.delete(i);
            end
        end
        if (!rst_n) begin
            prev_op = op_sel;
        end else if (op_sel !== prev_op) begin
            if (step_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_step cyc=%0d actual=%0d required=%0d",
                         cyc, op_sel, prev_op);
            end else begin
                cur = step_q.pop_front();
                check("step_cycle", cyc, cur.at);
                check("step_op", 32'(op_sel), 32'(cur.op));
                check("step_onehot", 32'(op_onehot), 32'(6'b000001 << cur.op));
                check("step_result", 32'(result), 32'(cur.res));
            end
            prev_op = op_sel;
        end
    end

    initial begin
        tick(3);
        push_snap("reset_state", cyc, 3'd0, 1'b0);
        rst_n = 1'b1;
        sw0   = 1'b1;
        sw1   = 1'b0;
        tick(5);
        push_snap("a1_b0_and", cyc, 3'd0, 1'b0);

        // Operand latency: new value shows exactly 3 cycles after the change.
        sw1 = 1'b1;
        push_snap("a1_b1_latency_hold", cyc + 2, 3'd0, 1'b0);
        push_snap("a1_b1_and", cyc + 3, 3'd0, 1'b1);
        tick(5);
        sw0 = 1'b0;
        push_snap("a0_b1_latency_hold", cyc + 2, 3'd0, 1'b1);
        push_snap("a0_b1_and", cyc + 3, 3'd0, 1'b0);
        tick(5);
        sw0 = 1'b1;
        sw1 = 1'b0;
        tick(5);

        // Six clean presses walk NAND, OR, NOR, XOR, NOT, then wrap to AND.
        for (int i = 0; i < 6; i++) begin
            btn = 1'b1;
            push_step(cyc + 2 + DebCycles + 1);
            tick(10);
            btn = 1'b0;
            tick(10);
        end

        // Bounce: 2-cycle toggles, final toggle at +20 stays high; one step 7 cycles later.
        push_step(cyc + 20 + 2 + DebCycles + 1);
        for (int k = 0; k <= 10; k++) begin
            btn = (k % 2 == 0);
            tick(2);
        end
        tick(15);
        btn = 1'b0;
        tick(10);

        // Reset mid-debounce with the button held: back to AND, no step until re-press.
        btn = 1'b1;
        tick(4);
        rst_n  = 1'b0;
        exp_op = 3'd0;
        push_snap("reset_mid_debounce", cyc, 3'd0, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        push_snap("held_after_reset", cyc, 3'd0, 1'b0);
        btn = 1'b0;
        tick(10);
        btn = 1'b1;
        push_step(cyc + 2 + DebCycles + 1);
        tick(10);
        btn = 1'b0;
        tick(10);

`ifdef GATE_SEQ_AUTOSCAN_EN
        auto_en = 1'b1;
        for (int s = 1; s <= 6; s++) push_step(cyc + 2 + s * ScanCycles);
        tick(50);
        auto_en = 1'b0;
        tick(20);

        // Press whose step pulse coincides with the second scan tick: one advance only.
        auto_en = 1'b1;
        push_step(cyc + 2 + ScanCycles);
        tick(11);
        btn = 1'b1;
        push_step(cyc + 7);
        push_step(cyc + 7 + ScanCycles);
        tick(10);
        btn = 1'b0;
        tick(6);
        auto_en = 1'b0;
        tick(20);
`else
        auto_en = 1'b1;
        tick(100);
        push_snap("auto_ignored", cyc, exp_op, ResA1B0[exp_op]);
        auto_en = 1'b0;
        tick(5);
`endif

        tick(5);
        while (step_q.size() > 0) begin
            cur = step_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_step actual=none required=op %0d at cyc %0d", cur.op, cur.at);
        end
        while (snap_q.size() > 0) begin
            cur = snap_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_snapshot %s actual=unchecked required=cyc %0d",
                     cur.name, cur.at);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
